// File: rtl/joystick_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : joystick_spi_reader
//  Description : Mode-0 SPI master that polls a PmodJSTK-style joystick once
//                per sample period. Sends a 5-byte command frame (LED bits in
//                byte 0) and assembles 10-bit X/Y deflection plus 3 button
//                bits from the 5-byte reply.
//  Revision    : 1.0  initial release
// ============================================================================
module joystick_spi_reader #(
    parameter int SCLK_DIV      = 50,
    parameter int SS_SETUP      = 1500,
    parameter int BYTE_GAP      = 1000,
    parameter int SAMPLE_PERIOD = 1_000_000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] buttons,
    output logic       sample_valid,
    output logic       busy
);

    // Counter widths; a parameter of 1 still gets a 1-bit counter.
    localparam int c_PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_WS = (SS_SETUP > 1) ? $clog2(SS_SETUP) : 1;
    localparam int c_WD = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_WG = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam int c_WSD = (c_WS > c_WD) ? c_WS : c_WD;
    localparam int c_W  = (c_WSD > c_WG) ? c_WSD : c_WG;

    localparam logic [c_PW-1:0] c_P_LAST     = c_PW'(SAMPLE_PERIOD - 1);
    localparam logic [c_W-1:0]  c_SETUP_LAST = c_W'(SS_SETUP - 1);
    localparam logic [c_W-1:0]  c_DIV_LAST   = c_W'(SCLK_DIV - 1);
    localparam logic [c_W-1:0]  c_GAP_LAST   = c_W'(BYTE_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_PW-1:0] r_period;
    logic [c_W-1:0]  r_cnt;
    logic            r_phase;      // sclk level inside SHIFT
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_byte_idx;
    logic [1:0]      r_led;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_b0;
    logic [1:0]      r_b1;
    logic [7:0]      r_b2;
    logic [1:0]      r_b3;

    logic       w_wrap;
    logic       w_setup_end;
    logic       w_half_end;
    logic       w_gap_end;
    logic       w_bit_end;
    logic       w_last_bit;
    logic       w_last_byte;
    logic [7:0] w_tx_byte;

    assign w_wrap      = (r_period == c_P_LAST);
    assign w_setup_end = (r_cnt == c_SETUP_LAST);
    assign w_half_end  = (r_cnt == c_DIV_LAST);
    assign w_gap_end   = (r_cnt == c_GAP_LAST);
    assign w_bit_end   = w_half_end && r_phase;
    assign w_last_bit  = (r_bit_idx == 3'd0);
    assign w_last_byte = (r_byte_idx == 3'd4);
    assign w_tx_byte   = (r_byte_idx == 3'd0) ? {6'b100000, r_led} : 8'h00;

    // Bus outputs decode directly from state so reset forces them at once.
    assign ss           = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_GAP));
    assign sclk         = (r_state == S_SHIFT) && r_phase;
    assign mosi         = (r_state == S_SHIFT) && w_tx_byte[r_bit_idx];
    assign sample_valid = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a period wrap outside IDLE is simply ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_wrap) w_state_nxt = S_SETUP;
            S_SETUP: if (w_setup_end) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = w_last_byte ? S_DONE : S_GAP;
            S_GAP:   if (w_gap_end) w_state_nxt = S_SHIFT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Period counter, bit timing, receive staging and output update.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_period   <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_led      <= 2'b00;
            r_rx_shift <= 8'h00;
            r_b0       <= 8'h00;
            r_b1       <= 2'b00;
            r_b2       <= 8'h00;
            r_b3       <= 2'b00;
            joy_x      <= 10'd512;
            joy_y      <= 10'd512;
            buttons    <= 3'b000;
        end else begin
            r_period <= w_wrap ? '0 : r_period + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                    if (w_wrap) begin
                        r_led      <= led;
                        r_byte_idx <= 3'd0;
                        r_bit_idx  <= 3'd7;
                    end
                end
                S_SETUP: begin
                    r_cnt <= w_setup_end ? '0 : r_cnt + 1'b1;
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            // sclk rising edge: capture the slave's bit.
                            r_rx_shift <= {r_rx_shift[6:0], miso};
                        end else if (w_last_bit) begin
                            r_bit_idx <= 3'd7;
                            case (r_byte_idx)
                                3'd0: r_b0 <= r_rx_shift;
                                3'd1: r_b1 <= r_rx_shift[1:0];
                                3'd2: r_b2 <= r_rx_shift;
                                3'd3: r_b3 <= r_rx_shift[1:0];
                                3'd4: begin
                                    joy_x   <= {r_b1, r_b0};
                                    joy_y   <= {r_b3, r_b2};
                                    buttons <= r_rx_shift[2:0];
                                end
                                default: ;
                            endcase
                        end else begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt      <= '0;
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joystick_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joystick_spi_reader
//  Description : Self-checking bench for joystick_spi_reader with a mode-0
//                slave model, a vector table and a scoreboard queue, plus
//                reset and sample-drop sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_joystick_spi_reader;

    typedef struct {
        logic [1:0]  led;
        logic [39:0] rx;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [7:0]  m0;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [1:0] led;
    logic       miso;
    logic       sclk, mosi, ss, sample_valid, busy;
    logic [9:0] joy_x, joy_y;
    logic [2:0] buttons;

    logic       clr_n_d;
    logic       miso_d = 1'b0;
    logic [1:0] led_d = 2'b00;
    logic       sclk_d, mosi_d, ss_d, sample_valid_d, busy_d;
    logic [9:0] joy_x_d, joy_y_d;
    logic [2:0] buttons_d;

    int total = 0;
    int bad = 0;

    logic [39:0] slave_frame;
    logic [39:0] s_sh;
    logic [39:0] mosi_frame;
    int          cyc = 0;
    int          t_ssfall = 0;
    int          nrise = 0;
    int          rise_t[64];
    int          sclk_bad = 0;
    int          sv_cnt = 0;

    vec_t vecs[4];
    vec_t sb[$];

    joystick_spi_reader #(
        .SCLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .SAMPLE_PERIOD(400)
    ) dut (
        .clk(clk), .clr_n(clr_n), .led(led), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss),
        .joy_x(joy_x), .joy_y(joy_y), .buttons(buttons),
        .sample_valid(sample_valid), .busy(busy)
    );

    joystick_spi_reader #(
        .SCLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .SAMPLE_PERIOD(100)
    ) dut_drop (
        .clk(clk), .clr_n(clr_n_d), .led(led_d), .miso(miso_d),
        .sclk(sclk_d), .mosi(mosi_d), .ss(ss_d),
        .joy_x(joy_x_d), .joy_y(joy_y_d), .buttons(buttons_d),
        .sample_valid(sample_valid_d), .busy(busy_d)
    );

    always #5 clk = ~clk;

    // Cycle stamp advances on the falling edge so posedge events read it stably.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sample_valid) sv_cnt = sv_cnt + 1;
    end

    // Slave: first bit presented at ss fall, next bit after each sclk fall.
    always @(negedge ss) begin
        s_sh       = slave_frame;
        miso       = s_sh[39];
        t_ssfall   = cyc;
        nrise      = 0;
        mosi_frame = '0;
    end

    always @(negedge sclk) begin
        s_sh = {s_sh[38:0], 1'b0};
        miso = s_sh[39];
    end

    always @(posedge sclk) begin
        if (nrise < 64) rise_t[nrise] = cyc;
        nrise      = nrise + 1;
        mosi_frame = {mosi_frame[38:0], mosi};
        if (ss) sclk_bad = sclk_bad + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Release reset and count clock edges until ss falls (-1 on timeout).
    task automatic release_and_measure(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            n = n + 1;
            #1;
            if (!ss) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) n = -1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   n;
        int   sv_snap;
        int   sp_bad;
        int   lim;
        bit   ok;
        vec_t e;
        int   falls[8];
        int   rises[8];
        int   nf;
        int   nr;
        logic prev;

        vecs[0] = '{led: 2'b10, rx: 40'h2C_03_10_00_05, x: 10'd812,  y: 10'd16,   btn: 3'b101, m0: 8'h82};
        vecs[1] = '{led: 2'b01, rx: 40'hFF_FF_00_FC_F8, x: 10'd1023, y: 10'd0,    btn: 3'b000, m0: 8'h81};
        vecs[2] = '{led: 2'b00, rx: 40'h00_00_FF_03_07, x: 10'd0,    y: 10'd1023, btn: 3'b111, m0: 8'h80};
        vecs[3] = '{led: 2'b11, rx: 40'h55_02_AA_01_12, x: 10'd597,  y: 10'd426,  btn: 3'b010, m0: 8'h83};

        clr_n       = 1'b0;
        clr_n_d     = 1'b0;
        led         = 2'b00;
        slave_frame = '0;
        miso        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_joy_x", joy_x, 512);
        chk("rst_joy_y", joy_y, 512);
        chk("rst_buttons", buttons, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);

        led         = vecs[0].led;
        slave_frame = vecs[0].rx;
        sb.push_back(vecs[0]);
        release_and_measure(n);
        chk("ss_fall_after_reset", n, 400);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                led         = vecs[i].led;
                slave_frame = vecs[i].rx;
                sb.push_back(vecs[i]);
            end
            sv_snap = sv_cnt;
            wait_done(ok);
            chk("done_seen", ok, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("joy_x", joy_x, e.x);
                chk("joy_y", joy_y, e.y);
                chk("buttons", buttons, e.btn);
                chk("mosi_frame", mosi_frame, {e.m0, 32'h0});
                chk("sclk_rises", nrise, 40);
                chk("ss_to_first_rise", rise_t[0] - t_ssfall, 6);
                sp_bad = 0;
                lim = (nrise < 40) ? nrise : 40;
                for (int k = 1; k < lim; k++) begin
                    if (rise_t[k] - rise_t[k-1] != (((k % 8) == 0) ? 7 : 4)) sp_bad = sp_bad + 1;
                end
                chk("sclk_spacing", sp_bad, 0);
                repeat (150) @(posedge clk);
                #1;
                chk("hold_joy_x", joy_x, e.x);
                chk("hold_joy_y", joy_y, e.y);
                chk("hold_buttons", buttons, e.btn);
                chk("one_valid_pulse", sv_cnt - sv_snap, 1);
            end else begin
                chk("scoreboard_empty", 0, 1);
            end
        end

        // Reset in the middle of byte 2
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (!ss && nrise >= 18) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reached_byte2", ok, 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_joy_x", joy_x, 512);
        chk("midrst_joy_y", joy_y, 512);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        release_and_measure(n);
        chk("ss_fall_after_midrst", n, 400);

        // Drop rule on the short-period instance
        nf = 0;
        nr = 0;
        prev = 1'b1;
        @(negedge clk);
        clr_n_d = 1'b1;
        for (int k = 1; k <= 900; k++) begin
            @(posedge clk);
            #1;
            if (prev && !ss_d && nf < 8) begin
                falls[nf] = k;
                nf = nf + 1;
            end
            if (!prev && ss_d && nr < 8) begin
                rises[nr] = k;
                nr = nr + 1;
            end
            prev = ss_d;
        end
        chk("drop_enough_frames", (nf >= 3 && nr >= 1), 1);
        if (nf >= 3 && nr >= 1) begin
            chk("drop_first_start", falls[0], 100);
            chk("drop_spacing_1", falls[1] - falls[0], 200);
            chk("drop_spacing_2", falls[2] - falls[1], 200);
            chk("drop_frame_low", rises[0] - falls[0], 176);
            chk("drop_ss_high_gap", (falls[1] - rises[0]) >= 23, 1);
        end

        chk("sclk_while_ss_high", sclk_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
